// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Fetch lookup is combinational; execute-stage resolution updates the table,
// raises a registered flush/redirect on mispredict and counts branches/misses.
module branch_predictor #(
  parameter int unsigned IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_inst,
  input  logic        ex_jump,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic [15:0] br_cnt,
  output logic [15:0] miss_cnt
);

  localparam int unsigned ENTRIES = 1 << IDX_W;
  localparam int unsigned TAG_W   = 30 - IDX_W;
  localparam int unsigned CNT_W   = 16;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] CTR_RESET = 2'b01;
  localparam logic [1:0] CTR_ALLOC = 2'b10;
  localparam logic [1:0] CTR_MAX   = 2'b11;
  localparam logic [1:0] CTR_MIN   = 2'b00;

  // Table storage: valid/ctr are reset, tag/target are plain storage
  logic              valid_q [ENTRIES];
  logic [TAG_W-1:0]  tag_q   [ENTRIES];
  logic [31:0]       tgt_q   [ENTRIES];
  logic [1:0]        ctr_q   [ENTRIES];

  logic              flush_q,    flush_d;
  logic [31:0]       redir_q,    redir_d;
  logic [CNT_W-1:0]  br_cnt_q,   br_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  // Fetch-side decode
  logic [IDX_W-1:0]  if_idx;
  logic [TAG_W-1:0]  if_tag;
  logic              if_is_br;
  logic              if_is_jal;
  logic              if_hit;

  // Execute-side decode
  logic [IDX_W-1:0]  ex_idx;
  logic [TAG_W-1:0]  ex_tag;
  logic              ex_is_br;
  logic              ex_is_jal;
  logic              ex_is_jalr;
  logic              ex_hit;
  logic              mispredict;

  // Single-entry write port
  logic              wr_en;
  logic              ent_valid_d;
  logic [TAG_W-1:0]  ent_tag_d;
  logic [31:0]       ent_tgt_d;
  logic [1:0]        ent_ctr_d;

  // Instruction fields above the opcode are not needed for prediction
  logic unused_inst_bits;
  assign unused_inst_bits = ^{if_inst[31:7], ex_inst[31:7]};

  assign if_idx    = if_pc[IDX_W+1:2];
  assign if_tag    = if_pc[31:IDX_W+2];
  assign if_is_br  = (if_inst[6:0] == OP_BRANCH);
  assign if_is_jal = (if_inst[6:0] == OP_JAL);
  assign if_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

  assign ex_idx     = ex_pc[IDX_W+1:2];
  assign ex_tag     = ex_pc[31:IDX_W+2];
  assign ex_is_br   = (ex_inst[6:0] == OP_BRANCH);
  assign ex_is_jal  = (ex_inst[6:0] == OP_JAL);
  assign ex_is_jalr = (ex_inst[6:0] == OP_JALR);
  assign ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  // Fetch prediction from pre-update table contents
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = if_pc + 32'd4;
    if (if_hit && (if_is_jal || (if_is_br && ctr_q[if_idx][1]))) begin
      pred_taken  = 1'b1;
      pred_target = tgt_q[if_idx];
    end
  end

  // Mispredict: wrong direction, or taken with the wrong target
  assign mispredict = ex_valid &&
                      ((ex_jump != ex_pred_taken) ||
                       (ex_jump && ex_pred_taken && (ex_pred_target != ex_target)));

  // Table update for the resolving instruction (JALR never touches the table)
  always_comb begin
    wr_en       = 1'b0;
    ent_valid_d = valid_q[ex_idx];
    ent_tag_d   = tag_q[ex_idx];
    ent_tgt_d   = tgt_q[ex_idx];
    ent_ctr_d   = ctr_q[ex_idx];
    if (ex_valid && (ex_is_br || ex_is_jal)) begin
      if (ex_hit) begin
        wr_en = 1'b1;
        if (ex_jump) begin
          ent_tgt_d = ex_target;
          if (ctr_q[ex_idx] != CTR_MAX) begin
            ent_ctr_d = ctr_q[ex_idx] + 2'd1;
          end
        end else if (ctr_q[ex_idx] != CTR_MIN) begin
          ent_ctr_d = ctr_q[ex_idx] - 2'd1;
        end
      end else if (ex_jump) begin
        wr_en       = 1'b1;
        ent_valid_d = 1'b1;
        ent_tag_d   = ex_tag;
        ent_tgt_d   = ex_target;
        ent_ctr_d   = CTR_ALLOC;
      end
    end
  end

  // Flush/redirect and saturating statistics counters
  always_comb begin
    flush_d    = mispredict;
    redir_d    = redir_q;
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (mispredict) begin
      redir_d = ex_jump ? ex_target : (ex_pc + 32'd4);
    end
    if (ex_valid && (ex_is_br || ex_is_jal || ex_is_jalr) && (br_cnt_q != '1)) begin
      br_cnt_d = br_cnt_q + CNT_W'(1);
    end
    if (mispredict && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
  end

  // Valid bits and counters: cleared/initialised by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_RESET;
      end
    end else if (wr_en) begin
      valid_q[ex_idx] <= ent_valid_d;
      ctr_q[ex_idx]   <= ent_ctr_d;
    end
  end

  // Tag and target storage: only written outside reset
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      tag_q[ex_idx] <= ent_tag_d;
      tgt_q[ex_idx] <= ent_tgt_d;
    end
  end

  // Control and statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_q    <= 1'b0;
      redir_q    <= 32'd0;
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      flush_q    <= flush_d;
      redir_q    <= redir_d;
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign flush       = flush_q;
  assign redirect_pc = redir_q;
  assign br_cnt      = br_cnt_q;
  assign miss_cnt    = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: driver pushes expectations from a
// behavioural table model, a negedge monitor pops and compares them.
module tb_branch_predictor;

  localparam int unsigned NENT = 16;
  localparam logic [31:0] BNE  = 32'h00829C63;
  localparam logic [31:0] JALR = 32'hF9C382E7;
  localparam logic [31:0] JAL  = 32'hFF5FF0EF;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc, if_inst;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_inst;
  logic        ex_jump;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [15:0] br_cnt, miss_cnt;

  branch_predictor #(.IDX_W(4)) dut (
    .clk(clk), .rst(rst),
    .if_pc(if_pc), .if_inst(if_inst),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_inst(ex_inst),
    .ex_jump(ex_jump), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .flush(flush), .redirect_pc(redirect_pc),
    .br_cnt(br_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: sel 0=pred_taken 1=pred_target 2=flush 3=redirect_pc 4=br_cnt 5=miss_cnt
  typedef struct {
    int          due;
    int          sel;
    logic [31:0] val;
    string       name;
  } item_t;

  item_t sb[$];
  item_t keep_q[$];
  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      0:       return {31'd0, pred_taken};
      1:       return pred_target;
      2:       return {31'd0, flush};
      3:       return redirect_pc;
      4:       return {16'd0, br_cnt};
      default: return {16'd0, miss_cnt};
    endcase
  endfunction

  task automatic expect_val(input int sel, input logic [31:0] val, input string name);
    item_t it;
    it.due = cyc; it.sel = sel; it.val = val; it.name = name;
    sb.push_back(it);
  endtask

  // Monitor: compare every expectation due in this cycle
  always @(negedge clk) begin
    foreach (sb[i]) begin
      if (sb[i].due == cyc) begin
        checks++;
        if (actual(sb[i].sel) !== sb[i].val) begin
          errors++;
          $display("FAIL %s cycle %0d: got %h expected %h", sb[i].name, cyc,
                   actual(sb[i].sel), sb[i].val);
        end
      end else if (sb[i].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s stale: due cycle %0d, now %0d, expected %h", sb[i].name,
                 sb[i].due, cyc, sb[i].val);
      end else begin
        keep_q.push_back(sb[i]);
      end
    end
    sb = keep_q;
    keep_q.delete();
  end

  // Behavioural model: 16-entry table, counters as integers 0..3
  bit          m_v   [NENT];
  int unsigned m_tag [NENT];
  logic [31:0] m_tgt [NENT];
  int          m_ctr [NENT];
  bit          m_flush;
  logic [31:0] m_redir;
  int          m_br, m_miss;
  bit          m_ok = 1'b0;

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc / 4) % NENT;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc / (4 * NENT);
  endfunction

  task automatic model_pred(input logic [31:0] pc, input logic [31:0] inst,
                            output bit t, output logic [31:0] tg);
    int unsigned i;
    bit hit, is_b, is_j;
    i    = idx_of(pc);
    hit  = m_v[i] && (m_tag[i] == tag_of(pc));
    is_b = (inst[6:0] == 7'h63);
    is_j = (inst[6:0] == 7'h6F);
    if (hit && (is_j || (is_b && m_ctr[i] >= 2))) begin
      t = 1'b1; tg = m_tgt[i];
    end else begin
      t = 1'b0; tg = pc + 32'd4;
    end
  endtask

  task automatic model_resolve(input logic [31:0] epc, input logic [31:0] einst,
                               input bit ej, input logic [31:0] etgt,
                               input bit ept, input logic [31:0] eptgt);
    bit is_b, is_j, is_r, mis, hit;
    int unsigned i;
    is_b = (einst[6:0] == 7'h63);
    is_j = (einst[6:0] == 7'h6F);
    is_r = (einst[6:0] == 7'h67);
    mis  = (ej != ept) || (ej && ept && (eptgt != etgt));
    if ((is_b || is_j || is_r) && m_br < 65535) m_br++;
    if (mis && m_miss < 65535) m_miss++;
    m_flush = mis;
    if (mis) m_redir = ej ? etgt : epc + 32'd4;
    if (is_b || is_j) begin
      i   = idx_of(epc);
      hit = m_v[i] && (m_tag[i] == tag_of(epc));
      if (hit) begin
        if (ej) begin
          if (m_ctr[i] < 3) m_ctr[i]++;
          m_tgt[i] = etgt;
        end else if (m_ctr[i] > 0) begin
          m_ctr[i]--;
        end
      end else if (ej) begin
        m_v[i] = 1'b1; m_tag[i] = tag_of(epc); m_tgt[i] = etgt; m_ctr[i] = 2;
      end
    end
  endtask

  // Apply one cycle of inputs and queue the model's expectations
  task automatic drive(input bit r, input logic [31:0] ipc, input logic [31:0] iinst,
                       input bit ev, input logic [31:0] epc, input logic [31:0] einst,
                       input bit ej, input logic [31:0] etgt,
                       input bit ept, input logic [31:0] eptgt);
    bit t;
    logic [31:0] tg;
    item_t it;
    rst = r; if_pc = ipc; if_inst = iinst;
    ex_valid = ev; ex_pc = epc; ex_inst = einst; ex_jump = ej; ex_target = etgt;
    ex_pred_taken = ept; ex_pred_target = eptgt;
    if (m_ok) begin
      model_pred(ipc, iinst, t, tg);
      expect_val(0, {31'd0, t}, "pred_taken");
      expect_val(1, tg, "pred_target");
    end
    if (r) begin
      for (int i = 0; i < NENT; i++) begin
        m_v[i] = 1'b0; m_ctr[i] = 1;
      end
      m_flush = 1'b0; m_redir = 32'd0; m_br = 0; m_miss = 0;
      m_ok = 1'b1;
    end else if (m_ok) begin
      if (ev) model_resolve(epc, einst, ej, etgt, ept, eptgt);
      else    m_flush = 1'b0;
    end
    if (m_ok) begin
      it.due = cyc + 1;
      it.sel = 2; it.val = {31'd0, m_flush};  it.name = "flush";       sb.push_back(it);
      it.sel = 3; it.val = m_redir;            it.name = "redirect_pc"; sb.push_back(it);
      it.sel = 4; it.val = 32'(m_br);          it.name = "br_cnt";      sb.push_back(it);
      it.sel = 5; it.val = 32'(m_miss);        it.name = "miss_cnt";    sb.push_back(it);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] ipc, input logic [31:0] iinst);
    drive(1'b0, ipc, iinst, 1'b0, $urandom, $urandom, 1'($urandom), $urandom,
          1'($urandom), $urandom);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 3))
      0:       v[6:0] = 7'h63;
      1:       v[6:0] = 7'h6F;
      2:       v[6:0] = 7'h67;
      default: v[6:0] = 7'h33;
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0] ipc, iinst, epc, einst, etgt, ptg;
    bit ev, ej, pt, r;

    rst = 1'b1; if_pc = '0; if_inst = '0; ex_valid = 1'b0; ex_pc = '0; ex_inst = '0;
    ex_jump = 1'b0; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
    tick();
    drive(1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    expect_val(2, 32'd0, "reset_flush");
    expect_val(4, 32'd0, "reset_br_cnt");

    // Cold lookup
    idle(32'h40, BNE);
    expect_val(0, 32'd0, "cold_taken");
    expect_val(1, 32'h44, "cold_target");
    tick();

    // Taken bne allocates and mispredicts
    drive(1'b0, 32'h40, BNE, 1'b1, 32'h40, BNE, 1'b1, 32'h58, 1'b0, 32'h44);
    tick();
    expect_val(2, 32'd1, "alloc_flush");
    expect_val(3, 32'h58, "alloc_redirect");
    idle(32'h40, BNE);
    expect_val(0, 32'd1, "trained_taken");
    expect_val(1, 32'h58, "trained_target");
    tick();
    expect_val(2, 32'd0, "flush_one_cycle");

    // Two not-taken resolutions: 10 -> 01 -> 00
    drive(1'b0, 32'h40, BNE, 1'b1, 32'h40, BNE, 1'b0, 32'h58, 1'b1, 32'h58);
    tick();
    expect_val(2, 32'd1, "nt1_flush");
    expect_val(3, 32'h44, "nt1_redirect");
    drive(1'b0, 32'h40, BNE, 1'b1, 32'h40, BNE, 1'b0, 32'h58, 1'b0, 32'h44);
    tick();
    expect_val(2, 32'd0, "nt2_no_flush");
    expect_val(3, 32'h44, "nt2_redirect_hold");
    idle(32'h40, BNE);
    expect_val(0, 32'd0, "nt_pred_taken");
    tick();

    // JALR always mispredicts, leaves the table alone
    drive(1'b0, 32'h40, BNE, 1'b1, 32'h40, JALR, 1'b1, 32'h100, 1'b0, 32'h44);
    tick();
    expect_val(2, 32'd1, "jalr_flush");
    expect_val(3, 32'h100, "jalr_redirect");
    expect_val(5, 32'd3, "jalr_miss_cnt");
    expect_val(4, 32'd4, "jalr_br_cnt");
    idle(32'h40, BNE);
    expect_val(0, 32'd0, "jalr_no_table_change");
    tick();

    // JAL allocate with same-cycle lookup seeing old contents
    drive(1'b0, 32'h80, JAL, 1'b1, 32'h80, JAL, 1'b1, 32'h20, 1'b0, 32'h84);
    expect_val(0, 32'd0, "jal_same_cycle");
    tick();
    idle(32'h80, JAL);
    expect_val(0, 32'd1, "jal_next_cycle");
    expect_val(1, 32'h20, "jal_next_target");
    tick();

    // Mispredict followed by reset; ex inputs during reset are ignored
    drive(1'b0, 32'h80, JAL, 1'b1, 32'h10, BNE, 1'b1, 32'h30, 1'b0, 32'h14);
    tick();
    expect_val(2, 32'd1, "pre_rst_flush");
    drive(1'b1, 32'h80, JAL, 1'b1, 32'h80, JAL, 1'b1, 32'h20, 1'b0, 32'h84);
    tick();
    expect_val(2, 32'd0, "rst_kills_flush");
    expect_val(3, 32'd0, "rst_redirect");
    expect_val(4, 32'd0, "rst_br_cnt");
    expect_val(5, 32'd0, "rst_miss_cnt");
    idle(32'h80, JAL);
    expect_val(0, 32'd0, "rst_forgets_jal");
    expect_val(1, 32'h84, "rst_target");
    tick();

    // Randomised traffic over a small PC space to force hits and aliasing
    for (int n = 0; n < 3000; n++) begin
      ipc   = 32'($urandom_range(0, 63)) * 32'd4;
      iinst = rand_inst();
      ev    = ($urandom_range(0, 9) != 0);
      epc   = 32'($urandom_range(0, 63)) * 32'd4;
      einst = rand_inst();
      case (einst[6:0])
        7'h63:        ej = 1'($urandom);
        7'h6F, 7'h67: ej = 1'b1;
        default:      ej = ($urandom_range(0, 15) == 0);
      endcase
      etgt = 32'h200 + 32'($urandom_range(0, 15)) * 32'd4;
      model_pred(epc, einst, pt, ptg);
      if ($urandom_range(0, 3) == 0) begin
        pt  = 1'($urandom);
        ptg = 32'h200 + 32'($urandom_range(0, 15)) * 32'd4;
      end
      r = ($urandom_range(0, 199) == 0);
      drive(r, ipc, iinst, ev, epc, einst, ej, etgt, pt, ptg);
      tick();
    end

    idle(32'h0, 32'h0);
    tick();
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameter IDX_W, default 4, giving log2 of the table entry count (16 entries).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-004 The block SHALL have port if_pc, input, 32, the fetch-stage PC.
REQ-005 The block SHALL have port if_inst, input, 32, the fetch-stage instruction.
REQ-006 The block SHALL have port pred_taken, output, 1, the fetch-stage taken prediction (combinational).
REQ-007 The block SHALL have port pred_target, output, 32, the predicted target; equal to if_pc+4 when pred_taken=0.
REQ-008 The block SHALL have port ex_valid, input, 1, marking a valid instruction in the execute stage.
REQ-009 The block SHALL have ports ex_pc and ex_inst, input, 32 each, the execute-stage PC and instruction.
REQ-010 The block SHALL have port ex_jump, input, 1, the resolved taken/not-taken result from the branch compare unit.
REQ-011 The block SHALL have port ex_target, input, 32, the resolved target address.
REQ-012 The block SHALL have ports ex_pred_taken (1 bit) and ex_pred_target (32 bits), input, the prediction carried down the pipeline with the instruction.
REQ-013 The block SHALL have port flush, output, 1, a registered one-cycle pulse on mispredict.
REQ-014 The block SHALL have port redirect_pc, output, 32, the registered correct next PC, valid while flush=1.
REQ-015 The block SHALL have ports br_cnt and miss_cnt, output, 16 each, the resolved-branch and mispredict counters.

Function
REQ-016 Each entry SHALL hold valid, tag = pc[31:IDX_W+2], target[31:0], and ctr[1:0]; index = pc[IDX_W+1:2].
REQ-017 Predictable classes SHALL be B-type (opcode 1100011) and JAL (opcode 1101111); JALR (1100111) and all other opcodes are never predicted.
REQ-018 pred_taken SHALL be 1 iff if_inst is predictable, the entry is valid, the tag matches, and ctr[1]=1 (JAL requires only a valid tag hit); pred_target = entry target in that case.
REQ-019 When ex_valid=1 and ex_inst is predictable with a tag hit, the counter SHALL saturate-increment on ex_jump=1 and saturate-decrement on ex_jump=0 (00 and 11 hold), and the target SHALL be rewritten with ex_target when ex_jump=1.
REQ-020 On a tag miss or invalid entry with ex_jump=1, the block SHALL allocate (overwrite) the entry: valid=1, new tag, target=ex_target, ctr=10.
REQ-021 On a tag miss with ex_jump=0, the block SHALL make no table change.
REQ-022 A mispredict SHALL be ex_valid & (ex_jump != ex_pred_taken | (ex_jump & ex_pred_taken & ex_pred_target != ex_target)); a JALR with ex_jump=1 therefore always mispredicts and does not touch the table.
REQ-023 On a mispredict in cycle N, flush SHALL be 1 in cycle N+1 only, with redirect_pc = ex_target if ex_jump else ex_pc+4; otherwise flush=0 and redirect_pc holds its last value.
REQ-024 A fetch lookup and an execute update to the same index in the same cycle SHALL return the pre-update contents to the lookup.
REQ-025 br_cnt SHALL increment on each ex_valid B-type/JAL/JALR instruction, and miss_cnt on each mispredict; both saturate at 0xFFFF.
REQ-026 With ex_valid=0, no table, counter, or flush activity SHALL occur.

Reset
REQ-027 While rst=1 at a clock edge, all valid bits, flush, redirect_pc, br_cnt, and miss_cnt SHALL clear to 0, all ctr SHALL become 01, and ex inputs in that cycle SHALL be ignored.
REQ-028 A rst asserted in the cycle after a mispredict SHALL force flush=0 in the following cycle.

Verification
REQ-029 Scenario: after reset, if_inst=0x00829C63, if_pc=0x40 -> pred_taken=0, pred_target=0x44.
REQ-030 Scenario: EX bne 0x00829C63 @0x40, ex_jump=1, ex_target=0x58, ex_pred_taken=0 -> next cycle flush=1, redirect_pc=0x58; entry ctr=10; a fetch at 0x40 then gives pred_taken=1, pred_target=0x58.
REQ-031 Scenario: the same branch resolves not-taken twice with matching predictions -> ctr 10->01->00; the first resolution flushes to 0x44; fetch at 0x40 then gives pred_taken=0.
REQ-032 Scenario: EX JALR 0xF9C382E7, ex_jump=1, ex_target=0x100 -> flush=1, redirect_pc=0x100, no table change, miss_cnt+1.
REQ-033 Scenario: EX JAL 0xFF5FF0EF @0x80 allocates the entry, then the same-index fetch in the same cycle -> pred_taken=0 (old contents); the next-cycle fetch -> pred_taken=1.
REQ-034 Scenario: rst pulsed mid-stream -> all outputs 0, counters 0, previously trained PC predicts not-taken.
